// File: rtl/bp_perceptron_pipe.sv
// rtl/bp_perceptron_pipe.sv - pipelined perceptron branch predictor with in-order resolve FIFO
// Optional feature macro: BP_GSHARE_INDEX_EN (XOR low ghr bits into the table index)
module bp_perceptron_pipe #(
  parameter int ADDR_WID           = 32,
  parameter int HASH_LENGTH        = 6,
  parameter int PERCEPTRON_HISTORY = 16,
  parameter int PERCEPTRON_BITS    = 8,
  parameter int THETA              = 45,
  parameter int INFLIGHT_DEPTH     = 4,
  localparam int SUM_W = PERCEPTRON_BITS + $clog2(PERCEPTRON_HISTORY + 1) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic [ADDR_WID-1:0]     req_addr,
  output logic                    req_ready,
  output logic                    pred_valid,
  output logic                    prediction,
  output logic signed [SUM_W-1:0] pred_sum,
  input  logic                    res_valid,
  input  logic                    res_taken,
  output logic                    mispredict,
  output logic                    res_err
);
  localparam int NUM_PERCEPTRONS = 2 ** HASH_LENGTH;
  localparam int H     = PERCEPTRON_HISTORY;
  localparam int B     = PERCEPTRON_BITS;
  localparam int PTR_W = $clog2(INFLIGHT_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]       DEPTH_C = CNT_W'(INFLIGHT_DEPTH);
  localparam logic signed [B-1:0]    W_MAX   = {1'b0, {(B-1){1'b1}}};
  localparam logic signed [B-1:0]    W_MIN   = {1'b1, {(B-1){1'b0}}};
  localparam logic signed [B-1:0]    W_ONE   = B'(1);
  localparam logic signed [SUM_W-1:0] THETA_S = SUM_W'(THETA);

  // weights[row][0] is the bias weight, weights[row][i] pairs with ghr[i-1]
  logic signed [B-1:0]       weights [NUM_PERCEPTRONS][H+1];
  logic [H-1:0]              ghr;
  logic [HASH_LENGTH-1:0]    fifo_idx  [INFLIGHT_DEPTH];
  logic [H-1:0]              fifo_snap [INFLIGHT_DEPTH];
  logic signed [SUM_W-1:0]   fifo_y    [INFLIGHT_DEPTH];
  logic [PTR_W-1:0]          rd_ptr, wr_ptr, wr_slot;
  logic [CNT_W-1:0]          count;

  logic                      full, accept, resolve, mis, train, req_pred;
  logic [HASH_LENGTH-1:0]    req_idx, head_idx;
  logic [H-1:0]              head_snap, ghr_eff, ghr_next;
  logic signed [SUM_W-1:0]   head_y, head_abs, req_sum;
  logic signed [B-1:0]       trained [H+1];
  logic                      unused_addr_bits;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [B-1:0] w);
    return {{(SUM_W-B){w[B-1]}}, w};
  endfunction

  function automatic logic signed [B-1:0] sat_step(input logic signed [B-1:0] w, input logic up);
    if (up) return (w == W_MAX) ? w : w + W_ONE;
    else    return (w == W_MIN) ? w : w - W_ONE;
  endfunction

  assign full      = (count == DEPTH_C);
  assign req_ready = !full;
  assign accept    = req_valid && !full;
  assign resolve   = res_valid && (count != '0);
  assign head_idx  = fifo_idx[rd_ptr];
  assign head_snap = fifo_snap[rd_ptr];
  assign head_y    = fifo_y[rd_ptr];
  assign head_abs  = head_y[SUM_W-1] ? -head_y : head_y;
  assign mis       = resolve && (!head_y[SUM_W-1] != res_taken);
  assign train     = resolve && (mis || (head_abs <= THETA_S));
  // A mispredicting resolve is older than a same-cycle request, so the request sees repaired history
  assign ghr_eff   = mis ? {head_snap[H-2:0], res_taken} : ghr;
  assign req_pred  = !req_sum[SUM_W-1];
  assign ghr_next  = accept ? {ghr_eff[H-2:0], req_pred} : ghr_eff;
  assign wr_slot   = mis ? '0 : wr_ptr;
  assign unused_addr_bits = ^{req_addr[ADDR_WID-1:HASH_LENGTH+2], req_addr[1:0]};

`ifdef BP_GSHARE_INDEX_EN
  assign req_idx = req_addr[HASH_LENGTH+1:2] ^ ghr_eff[HASH_LENGTH-1:0];
`else
  assign req_idx = req_addr[HASH_LENGTH+1:2];
`endif

  // Perceptron dot product against the (possibly repaired) speculative history
  always_comb begin
    req_sum = sext(weights[req_idx][0]);
    for (int i = 1; i <= H; i++) begin
      if (ghr_eff[i-1]) req_sum = req_sum + sext(weights[req_idx][i]);
      else              req_sum = req_sum - sext(weights[req_idx][i]);
    end
  end

  // Saturating +/-1 step for each weight of the resolving row
  always_comb begin
    for (int i = 0; i <= H; i++) trained[i] = weights[head_idx][i];
    trained[0] = sat_step(weights[head_idx][0], res_taken);
    for (int i = 1; i <= H; i++)
      trained[i] = sat_step(weights[head_idx][i], head_snap[i-1] == res_taken);
  end

  // Weight table: cleared on reset, trained row written on resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_PERCEPTRONS; r++)
        for (int i = 0; i <= H; i++) weights[r][i] <= '0;
    end else if (train) begin
      for (int i = 0; i <= H; i++) weights[head_idx][i] <= trained[i];
    end
  end

  // FIFO payload; after a flush the concurrent request lands in slot 0
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_idx[wr_slot]  <= req_idx;
      fifo_snap[wr_slot] <= ghr_eff;
      fifo_y[wr_slot]    <= req_sum;
    end
  end

  // FIFO pointers, occupancy and speculative history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ghr    <= '0;
    end else begin
      ghr <= ghr_next;
      if (mis) begin
        rd_ptr <= '0;
        wr_ptr <= accept ? PTR_W'(1) : '0;
        count  <= accept ? CNT_W'(1) : '0;
      end else begin
        if (resolve) rd_ptr <= rd_ptr + PTR_W'(1);
        if (accept)  wr_ptr <= wr_ptr + PTR_W'(1);
        case ({accept, resolve})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Registered prediction and resolve status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      prediction <= 1'b0;
      pred_sum   <= '0;
      mispredict <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      pred_valid <= accept;
      if (accept) begin
        prediction <= req_pred;
        pred_sum   <= req_sum;
      end
      mispredict <= mis;
      res_err    <= res_valid && (count == '0);
    end
  end
endmodule

// File: tb/tb_bp_perceptron_pipe.sv
// tb/tb_bp_perceptron_pipe.sv - random and directed check of bp_perceptron_pipe against a list model
module tb_bp_perceptron_pipe;
  localparam int H  = 16;
  localparam int NP = 64;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic res_valid = 1'b0;
  logic res_taken = 1'b0;
  logic [1:0] req_ready, pred_valid, prediction, mispredict, res_err;
  logic signed [13:0] pred_sum [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_perceptron_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready[0]), .pred_valid(pred_valid[0]), .prediction(prediction[0]),
    .pred_sum(pred_sum[0]), .res_valid(res_valid), .res_taken(res_taken),
    .mispredict(mispredict[0]), .res_err(res_err[0])
  );

  bp_perceptron_pipe #(.THETA(4000)) u_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready[1]), .pred_valid(pred_valid[1]), .prediction(prediction[1]),
    .pred_sum(pred_sum[1]), .res_valid(res_valid), .res_taken(res_taken),
    .mispredict(mispredict[1]), .res_err(res_err[1])
  );

  // reference model: one copy per instance, in-flight branches kept as an ordered list
  typedef struct { int idx; logic [15:0] snap; int y; } ent_t;
  int          w     [2][NP][H+1];
  logic [15:0] ghr_m [2];
  ent_t        q     [2][D];
  int          qn    [2];
  bit          exp_pv [2], exp_pred [2], exp_mis [2], exp_err [2];
  int          exp_sum [2];

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NP; r++)
        for (int i = 0; i <= H; i++) w[k][r][i] = 0;
      ghr_m[k] = '0; qn[k] = 0;
      exp_pv[k] = 0; exp_pred[k] = 0; exp_mis[k] = 0; exp_err[k] = 0; exp_sum[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int th, input bit rv, input logic [31:0] a,
                            input bit resv, input bit tk);
    bit accept, mis, train;
    ent_t h;
    logic [15:0] g;
    int idx, y, t;
    g = ghr_m[k];
    accept = rv && (qn[k] < D);
    mis = 0; train = 0; idx = 0; y = 0;
    h.idx = 0; h.snap = '0; h.y = 0;
    exp_pv[k] = 0; exp_mis[k] = 0; exp_err[k] = 0;
    if (resv) begin
      if (qn[k] == 0) exp_err[k] = 1;
      else begin
        h = q[k][0];
        for (int j = 0; j < qn[k] - 1; j++) q[k][j] = q[k][j+1];
        qn[k]--;
        mis   = ((h.y >= 0) != tk);
        train = mis || ((h.y < 0 ? -h.y : h.y) <= th);
        if (mis) begin
          g = {h.snap[14:0], tk};
          qn[k] = 0;
          exp_mis[k] = 1;
        end
      end
    end
    if (accept) begin
`ifdef BP_GSHARE_INDEX_EN
      idx = int'(a[7:2] ^ g[5:0]);
`else
      idx = int'(a[7:2]);
`endif
      y = w[k][idx][0];
      for (int i = 1; i <= H; i++) y += g[i-1] ? w[k][idx][i] : -w[k][idx][i];
      exp_pv[k] = 1; exp_pred[k] = (y >= 0); exp_sum[k] = y;
    end
    if (train) begin
      t = tk ? 1 : -1;
      w[k][h.idx][0] = sat(w[k][h.idx][0] + t);
      for (int i = 1; i <= H; i++)
        w[k][h.idx][i] = sat(w[k][h.idx][i] + t * (h.snap[i-1] ? 1 : -1));
    end
    if (accept) begin
      q[k][qn[k]].idx = idx; q[k][qn[k]].snap = g; q[k][qn[k]].y = y;
      qn[k]++;
      g = {g[14:0], (y >= 0) ? 1'b1 : 1'b0};
    end
    ghr_m[k] = g;
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("pred_valid[%0d]", k), pred_valid[k], exp_pv[k]);
      if (exp_pv[k]) begin
        check($sformatf("prediction[%0d]", k), prediction[k], exp_pred[k]);
        check($sformatf("pred_sum[%0d]", k), pred_sum[k], exp_sum[k]);
      end
      check($sformatf("mispredict[%0d]", k), mispredict[k], exp_mis[k]);
      check($sformatf("res_err[%0d]", k), res_err[k], exp_err[k]);
    end
  endtask

  // one clock: drive at posedge+1, model, then check the registered results
  task automatic cycle(input bit rv, input logic [31:0] a, input bit resv, input bit tk);
    req_valid = rv; req_addr = a; res_valid = resv; res_taken = tk;
    for (int k = 0; k < 2; k++) check($sformatf("req_ready[%0d]", k), req_ready[k], qn[k] < D);
    model_step(0, 45, rv, a, resv, tk);
    model_step(1, 4000, rv, a, resv, tk);
    @(posedge clk); #1;
    check_outputs();
    req_valid = 0; res_valid = 0;
  endtask

  task automatic do_reset();
    req_valid = 0; res_valid = 0;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      check("rst_pred_valid", pred_valid[k], 0);
      check("rst_prediction", prediction[k], 0);
      check("rst_pred_sum", pred_sum[k], 0);
      check("rst_mispredict", mispredict[k], 0);
      check("rst_res_err", res_err[k], 0);
      check("rst_req_ready", req_ready[k], 1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int s2_sum [5];
    int s2_mis [5];
    s2_sum = '{0, -17, -34, -51, -51};
    s2_mis = '{1, 0, 0, 0, 0};
    @(posedge clk); #1;
    do_reset();

    // scenario 1: first prediction after reset
    cycle(1, 32'h40, 0, 0);
    check("s1_valid", pred_valid[0], 1);
    check("s1_pred", prediction[0], 1);
    check("s1_sum", pred_sum[0], 0);
    check("s1_ready", req_ready[0], 1);

    // scenarios 2/3: mispredict, retrain, theta cutoff
    do_reset();
    for (int n = 0; n < 5; n++) begin
      cycle(1, 32'h100, 0, 0);
      check("s2_sum", pred_sum[0], s2_sum[n]);
      cycle(0, 32'h0, 1, 0);
      check("s2_mis", mispredict[0], s2_mis[n]);
    end

    // scenario 4: full FIFO holds off the 5th request
    do_reset();
    for (int n = 0; n < 4; n++) cycle(1, 32'(n * 4), 0, 0);
    check("s4_full", req_ready[0], 0);
    cycle(1, 32'h10, 0, 0);
    check("s4_held", pred_valid[0], 0);
    cycle(1, 32'h10, 1, 1);
    check("s4_ready", req_ready[0], 1);
    cycle(1, 32'h10, 0, 0);
    check("s4_accept", pred_valid[0], 1);

    // scenario 5: flush with concurrent request leaves one entry
    do_reset();
    for (int n = 0; n < 3; n++) cycle(1, 32'(n * 4), 0, 0);
    cycle(1, 32'h0, 1, 0);
    check("s5_mis", mispredict[0], 1);
    check("s5_ready", req_ready[0], 1);
    for (int n = 0; n < 3; n++) cycle(1, 32'h8, 0, 0);
    check("s5_full", req_ready[0], 0);

    // scenario 6: saturation on the wide-theta instance, then empty resolve
    do_reset();
    for (int n = 0; n < 140; n++) begin
      cycle(1, 32'h100, 0, 0);
      cycle(0, 32'h0, 1, 0);
    end
    cycle(1, 32'h100, 0, 0);
    check("s6_sum", pred_sum[1], -2160);
    cycle(0, 32'h0, 1, 0);
    cycle(0, 32'h0, 1, 0);
    check("s6_err", res_err[1], 1);
    cycle(0, 32'h0, 0, 0);
    check("s6_err_pulse", res_err[1], 0);
    cycle(1, 32'h100, 0, 0);
    check("s6_sum_kept", pred_sum[1], -2160);

    // randomized traffic with a mid-run reset
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      cycle($urandom_range(0, 9) < 6, 32'($urandom_range(0, 3)) << 2,
            $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
